// File: rtl/control_unit_if.sv
// control_unit_if: the processor's sequencing bundle between the step
// controller and the datapath (bus mux, register file, ALU).
//   Run, IR   : start request and instruction register contents (to controller)
//   IRin      : load IR from DIN
//   Rout[0:7] : one-hot bus source select, bit 0 = R0
//   Rin[0:7]  : one-hot register load enable, bit 0 = R0
//   Gout      : G drives the bus
//   DINout    : DIN drives the bus
//   Ain, Gin  : load A from bus / load G from ALU
//   AddSub    : ALU mode, 0 = A+bus, 1 = A-bus
//   Done      : final step of the current instruction
interface control_unit_if;
  logic       Run;
  logic [8:0] IR;
  logic       IRin;
  logic [0:7] Rout;
  logic [0:7] Rin;
  logic       Gout;
  logic       DINout;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;

  // Datapath side: supplies Run/IR, consumes the control lines.
  modport master (
    output Run, IR,
    input  IRin, Rout, Rin, Gout, DINout, Ain, Gin, AddSub, Done
  );

  // Controller side.
  modport slave (
    input  Run, IR,
    output IRin, Rout, Rin, Gout, DINout, Ain, Gin, AddSub, Done
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: step-sequencing controller for the 16-bit processor.
// Decodes the 9-bit instruction III XXX YYY and walks a T0..T3 step counter,
// driving bus-source selects, register load enables, ALU mode and Done.
// Ports:
//   Clock : system clock, rising edge
//   Reset : asynchronous active-high; forces T0 and holds all outputs at 0
//   bus   : control_unit_if.slave (Run, IR in; control lines out)
module control_unit (
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.slave  bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_t;

  step_t      state, state_next;
  logic [2:0] op;
  logic [2:0] rx, ry;
  logic       is_arith;

  assign op       = bus.IR[8:6];
  assign rx       = bus.IR[5:3];
  assign ry       = bus.IR[2:0];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  // Register index to one-hot select; element 0 of the [0:7] vector is R0.
  function automatic logic [0:7] reg_sel(input logic [2:0] idx);
    logic [0:7] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= T0;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = T0;
    unique case (state)
      T0:      state_next = bus.Run ? T1 : T0;
      T1:      state_next = is_arith ? T2 : T0;
      T2:      state_next = T3;
      T3:      state_next = T0;
      default: state_next = T0;
    endcase
  end

  // Output logic. Reset is folded in combinationally so IRin cannot follow
  // Run while Reset is held, even though the state is already T0.
  always_comb begin
    bus.IRin   = 1'b0;
    bus.Rout   = '0;
    bus.Rin    = '0;
    bus.Gout   = 1'b0;
    bus.DINout = 1'b0;
    bus.Ain    = 1'b0;
    bus.Gin    = 1'b0;
    bus.AddSub = 1'b0;
    bus.Done   = 1'b0;
    if (!Reset) begin
      unique case (state)
        T0: bus.IRin = bus.Run;
        T1: begin
          unique case (op)
            OP_MV: begin
              bus.Rout = reg_sel(ry);
              bus.Rin  = reg_sel(rx);
              bus.Done = 1'b1;
            end
            OP_MVI: begin
              bus.DINout = 1'b1;
              bus.Rin    = reg_sel(rx);
              bus.Done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.Rout = reg_sel(rx);
              bus.Ain  = 1'b1;
            end
            default: bus.Done = 1'b1;
          endcase
        end
        T2: begin
          if (is_arith) begin
            bus.Rout   = reg_sel(ry);
            bus.Gin    = 1'b1;
            bus.AddSub = (op == OP_SUB);
          end
        end
        T3: begin
          if (is_arith) begin
            bus.Gout = 1'b1;
            bus.Rin  = reg_sel(rx);
            bus.Done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  control_unit_if bus ();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed view: {IRin, Rout[0:7], Rin[0:7], Gout, DINout, Ain, Gin, AddSub, Done}
  function automatic logic [31:0] ex(input logic irin, input logic [7:0] rout,
                                     input logic [7:0] rin, input logic gout,
                                     input logic dinout, input logic ain,
                                     input logic gin, input logic addsub,
                                     input logic done);
    return {9'b0, irin, rout, rin, gout, dinout, ain, gin, addsub, done};
  endfunction

  function automatic logic [31:0] obs();
    return {9'b0, bus.IRin, bus.Rout, bus.Rin, bus.Gout, bus.DINout,
            bus.Ain, bus.Gin, bus.AddSub, bus.Done};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  // Run one instruction from T0 and check each step against a hand-written vector.
  task automatic run_instr(input string tag, input logic [8:0] ir, input int unsigned nsteps,
                           input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    bus.IR  = ir;
    bus.Run = 1'b1;
    #1 check({tag, "_T0"}, obs(), ex(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
    tick();
    bus.Run = 1'b0;
    check({tag, "_T1"}, obs(), e1);
    if (nsteps > 1) begin
      tick();
      check({tag, "_T2"}, obs(), e2);
      tick();
      check({tag, "_T3"}, obs(), e3);
    end
    tick();
    check({tag, "_back_T0"}, obs(), '0);
  endtask

  logic [7:0] rx_exp;
  logic [7:0] rin_at_done;
  int         drivers;
  int         dones;
  int         done_step;
  int         lat_exp;

  initial begin
    Reset   = 1'b1;
    bus.Run = 1'b0;
    bus.IR  = '0;

    // Reset then idle
    #2 check("rst_outs", obs(), '0);
    bus.Run = 1'b1;
    #1 check("rst_irin_gated", obs(), '0);
    tick();
    check("rst_cycle2", obs(), '0);
    bus.Run = 1'b0;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("idle_T0", obs(), '0);
      tick();
    end

    // mv R2,R5
    run_instr("mv", 9'b000_010_101, 1,
              ex(0, 8'b00000100, 8'b00100000, 0, 0, 0, 0, 0, 1), '0, '0);
    // mvi R3,#D
    run_instr("mvi", 9'b001_011_000, 1,
              ex(0, 8'b0, 8'b00010000, 0, 1, 0, 0, 0, 1), '0, '0);
    // sub R0,R1
    run_instr("sub", 9'b011_000_001, 3,
              ex(0, 8'b10000000, 8'b0, 0, 0, 1, 0, 0, 0),
              ex(0, 8'b01000000, 8'b0, 0, 0, 0, 1, 1, 0),
              ex(0, 8'b0, 8'b10000000, 1, 0, 0, 0, 0, 1));
    // add R0,R1
    run_instr("add", 9'b010_000_001, 3,
              ex(0, 8'b10000000, 8'b0, 0, 0, 1, 0, 0, 0),
              ex(0, 8'b01000000, 8'b0, 0, 0, 0, 1, 0, 0),
              ex(0, 8'b0, 8'b10000000, 1, 0, 0, 0, 0, 1));
    // mv R3,R3 (X==Y)
    run_instr("mv_same", 9'b000_011_011, 1,
              ex(0, 8'b00010000, 8'b00010000, 0, 0, 0, 0, 0, 1), '0, '0);
    // add R2,R2
    run_instr("add_same", 9'b010_010_010, 3,
              ex(0, 8'b00100000, 8'b0, 0, 0, 1, 0, 0, 0),
              ex(0, 8'b00100000, 8'b0, 0, 0, 0, 1, 0, 0),
              ex(0, 8'b0, 8'b00100000, 1, 0, 0, 0, 0, 1));
    // undefined opcode
    run_instr("undef", 9'b111_001_010, 1,
              ex(0, 8'b0, 8'b0, 0, 0, 0, 0, 0, 1), '0, '0);

    // add R4,R6 with Reset during T2; Run held high to probe IRin gating
    bus.IR  = 9'b010_100_110;
    bus.Run = 1'b1;
    #1 check("abort_T0", obs(), ex(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
    tick();
    check("abort_T1", obs(), ex(0, 8'b00001000, 8'b0, 0, 0, 1, 0, 0, 0));
    tick();
    check("abort_T2", obs(), ex(0, 8'b00000010, 8'b0, 0, 0, 0, 1, 0, 0));
    Reset = 1'b1;
    #1 check("abort_rst_async", obs(), '0);
    bus.Run = 1'b0;
    #1 Reset = 1'b0;
    // Now in T0 with Run=0: must stay idle, no R4 load ever
    for (int i = 0; i < 3; i++) begin
      #1 check("abort_after_outs", obs(), '0);
      check("abort_no_rin", {24'b0, bus.Rin}, '0);
      tick();
    end

    // Exclusivity sweep over every IR and Run value
    for (int ir = 0; ir < 512; ir++) begin
      for (int r = 0; r < 2; r++) begin
        bus.IR  = ir[8:0];
        bus.Run = r[0];
        #1 check("sweep_T0", obs(), ex(r[0], 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
        tick();
        bus.Run     = 1'b0;
        dones       = 0;
        done_step   = 0;
        rin_at_done = '0;
        for (int k = 1; k <= 4; k++) begin
          drivers = $countones(bus.Rout) + int'(bus.Gout) + int'(bus.DINout);
          check("sweep_bus_excl", {31'b0, drivers <= 1}, 32'd1);
          check("sweep_rin_1hot", {31'b0, $onehot0(bus.Rin)}, 32'd1);
          check("sweep_rout_1hot", {31'b0, $onehot0(bus.Rout)}, 32'd1);
          if (bus.Done) begin
            dones++;
            done_step   = k;
            rin_at_done = bus.Rin;
          end
          tick();
        end
        check("sweep_done_count", dones, r);
        if (r == 1) begin
          lat_exp = (ir[8:6] == 3'b010 || ir[8:6] == 3'b011) ? 3 : 1;
          check("sweep_latency", done_step, lat_exp);
          rx_exp = (ir[8:6] <= 3'b011) ? (8'b1000_0000 >> ir[5:3]) : 8'b0;
          check("sweep_rin_done", {24'b0, rin_at_done}, {24'b0, rx_exp});
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
